uart_pwm_rx: RTL and testbench

Receive-side stage of the audio visualizer link. Consumes the serial stream produced by `uart_top` on its `tx` line. Deserializes 8N1 bytes with 16x oversampling and parses two-byte command frames (header `0xA5`, then a duty byte). Drives a glitch-free PWM output for the LED MOSFET driver.

---
 rtl/uart_pwm_rx.sv | 201 ++++++++++++++++++++
 tb/tb_uart_pwm_rx.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_pwm_rx.sv
// 8N1 UART receiver (16x oversampled) feeding a two-byte command parser
// that sets the duty of a glitch-free 8-bit PWM output.
module uart_pwm_rx #(
  parameter int         DBITS    = 8,
  parameter int         SB_TICK  = 16,
  parameter int         BR_LIMIT = 651,
  parameter int         BR_BITS  = 10,
  parameter int         PWM_DIV  = 16,
  parameter logic [7:0] HDR      = 8'hA5
) (
  input  logic             clk_100MHz,
  input  logic             reset,
  input  logic             rx,
  output logic [DBITS-1:0] rx_data,
  output logic             rx_done,
  output logic             frame_err,
  output logic [7:0]       duty,
  output logic             duty_upd,
  output logic             pwm_out
);
  localparam int S_W = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;
  localparam int N_W = (DBITS > 1) ? $clog2(DBITS) : 1;
  localparam int P_W = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;

  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
  typedef enum logic {P_HDR, P_DUTY} prs_state_t;

  logic               sync1_q, sync1_d, sync2_q, sync2_d;
  logic [BR_BITS-1:0] br_cnt_q, br_cnt_d;
  rx_state_t          state_q, state_d;
  logic [S_W-1:0]     s_q, s_d;
  logic [N_W-1:0]     n_q, n_d;
  logic [DBITS-1:0]   sh_q, sh_d;
  logic [DBITS-1:0]   rx_data_q, rx_data_d;
  logic               rx_done_q, rx_done_d;
  logic               frame_err_q, frame_err_d;
  prs_state_t         pstate_q, pstate_d;
  logic [7:0]         duty_pend_q, duty_pend_d;
  logic               pend_valid_q, pend_valid_d;
  logic [P_W-1:0]     pre_q, pre_d;
  logic [7:0]         pwm_cnt_q, pwm_cnt_d;
  logic [7:0]         duty_q, duty_d;
  logic               duty_upd_q, duty_upd_d;
  logic               pwm_out_q, pwm_out_d;

  logic       rx_s, tick, pre_wrap;
  logic [7:0] rx_byte;

  assign rx_s     = sync2_q;
  assign tick     = (br_cnt_q == BR_BITS'(BR_LIMIT - 1));
  assign pre_wrap = (pre_q == P_W'(PWM_DIV - 1));
  assign rx_byte  = rx_data_q[7:0];

  // synchronizer and oversampling tick
  always_comb begin
    sync1_d  = rx;
    sync2_d  = sync1_q;
    br_cnt_d = tick ? '0 : br_cnt_q + BR_BITS'(1);
  end

  // receiver: sample mid-bit, 16 ticks per bit after the half-bit start check
  always_comb begin
    state_d     = state_q;
    s_d         = s_q;
    n_d         = n_q;
    sh_d        = sh_q;
    rx_data_d   = rx_data_q;
    rx_done_d   = 1'b0;
    frame_err_d = 1'b0;
    case (state_q)
      R_IDLE: begin
        if (!rx_s) begin
          state_d = R_START;
          s_d     = '0;
        end
      end
      R_START: begin
        if (tick) begin
          if (s_q == S_W'(7)) begin
            s_d = '0;
            n_d = '0;
            state_d = rx_s ? R_IDLE : R_DATA;
          end else begin
            s_d = s_q + S_W'(1);
          end
        end
      end
      R_DATA: begin
        if (tick) begin
          if (s_q == S_W'(15)) begin
            s_d  = '0;
            sh_d = {rx_s, sh_q[DBITS-1:1]};
            if (n_q == N_W'(DBITS - 1)) state_d = R_STOP;
            else                        n_d = n_q + N_W'(1);
          end else begin
            s_d = s_q + S_W'(1);
          end
        end
      end
      R_STOP: begin
        if (tick) begin
          if (s_q == S_W'(SB_TICK - 1)) begin
            state_d = R_IDLE;
            if (rx_s) begin
              rx_data_d = sh_q;
              rx_done_d = 1'b1;
            end else begin
              frame_err_d = 1'b1;
            end
          end else begin
            s_d = s_q + S_W'(1);
          end
        end
      end
      default: state_d = R_IDLE;
    endcase
  end

  // parser, PWM counters and boundary-aligned duty load
  always_comb begin
    pstate_d     = pstate_q;
    duty_pend_d  = duty_pend_q;
    pend_valid_d = pend_valid_q;
    duty_d       = duty_q;
    duty_upd_d   = 1'b0;
    pre_d        = pre_wrap ? '0 : pre_q + P_W'(1);
    pwm_cnt_d    = pre_wrap ? pwm_cnt_q + 8'd1 : pwm_cnt_q;
    pwm_out_d    = (pwm_cnt_q < duty_q);

    if (pre_wrap && pwm_cnt_q == 8'hFF && pend_valid_q) begin
      duty_d       = duty_pend_q;
      pend_valid_d = 1'b0;
      duty_upd_d   = 1'b1;
    end

    // a frame completing on the boundary cycle stays pending for the next period
    if (frame_err_q) begin
      pstate_d = P_HDR;
    end else if (rx_done_q) begin
      case (pstate_q)
        P_HDR:  if (rx_byte == HDR) pstate_d = P_DUTY;
        P_DUTY: begin
          duty_pend_d  = rx_byte;
          pend_valid_d = 1'b1;
          pstate_d     = P_HDR;
        end
        default: pstate_d = P_HDR;
      endcase
    end
  end

  always_ff @(posedge clk_100MHz or negedge reset) begin
    if (!reset) begin
      sync1_q      <= 1'b1;
      sync2_q      <= 1'b1;
      br_cnt_q     <= '0;
      state_q      <= R_IDLE;
      s_q          <= '0;
      n_q          <= '0;
      sh_q         <= '0;
      rx_data_q    <= '0;
      rx_done_q    <= 1'b0;
      frame_err_q  <= 1'b0;
      pstate_q     <= P_HDR;
      duty_pend_q  <= '0;
      pend_valid_q <= 1'b0;
      pre_q        <= '0;
      pwm_cnt_q    <= '0;
      duty_q       <= '0;
      duty_upd_q   <= 1'b0;
      pwm_out_q    <= 1'b0;
    end else begin
      sync1_q      <= sync1_d;
      sync2_q      <= sync2_d;
      br_cnt_q     <= br_cnt_d;
      state_q      <= state_d;
      s_q          <= s_d;
      n_q          <= n_d;
      sh_q         <= sh_d;
      rx_data_q    <= rx_data_d;
      rx_done_q    <= rx_done_d;
      frame_err_q  <= frame_err_d;
      pstate_q     <= pstate_d;
      duty_pend_q  <= duty_pend_d;
      pend_valid_q <= pend_valid_d;
      pre_q        <= pre_d;
      pwm_cnt_q    <= pwm_cnt_d;
      duty_q       <= duty_d;
      duty_upd_q   <= duty_upd_d;
      pwm_out_q    <= pwm_out_d;
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_done   = rx_done_q;
  assign frame_err = frame_err_q;
  assign duty      = duty_q;
  assign duty_upd  = duty_upd_q;
  assign pwm_out   = pwm_out_q;

endmodule

// File: tb/tb_uart_pwm_rx.sv
// Randomized bench for uart_pwm_rx: serial driver, frame/duty reference model,
// pulse monitor and PWM high-time measurement. Fast baud/PWM parameters.
`timescale 1ns/1ps
module tb_uart_pwm_rx;
  localparam int DBITS    = 8;
  localparam int BR_LIMIT = 2;
  localparam int PWM_DIV  = 8;
  localparam int BIT_CLK  = BR_LIMIT * 16;
  localparam int PERIOD   = 256 * PWM_DIV;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       rx = 1'b1;
  logic [7:0] rx_data;
  logic       rx_done, frame_err, duty_upd, pwm_out;
  logic [7:0] duty;

  uart_pwm_rx #(
    .DBITS(DBITS), .SB_TICK(16), .BR_LIMIT(BR_LIMIT), .BR_BITS(4),
    .PWM_DIV(PWM_DIV), .HDR(8'hA5)
  ) dut (
    .clk_100MHz(clk), .reset(reset_n), .rx(rx), .rx_data(rx_data),
    .rx_done(rx_done), .frame_err(frame_err), .duty(duty),
    .duty_upd(duty_upd), .pwm_out(pwm_out)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  int n_done = 0, n_ferr = 0, n_upd = 0, n_wide = 0, cyc = 0;
  logic done_p = 1'b0, ferr_p = 1'b0, upd_p = 1'b0;
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];

  // reference model state
  bit         m_hdr = 0;
  bit         m_pv = 0;
  logic [7:0] m_pend = 8'h00;
  logic [7:0] m_duty = 8'h00;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset_n) cyc = 0; else cyc++;
    if (rx_done) begin n_done++; got_q.push_back(rx_data); end
    if (frame_err) n_ferr++;
    if (duty_upd) n_upd++;
    if ((rx_done && done_p) || (frame_err && ferr_p) || (duty_upd && upd_p)) n_wide++;
    done_p = rx_done;
    ferr_p = frame_err;
    upd_p  = duty_upd;
  end

  initial begin
    repeat (90000) @(posedge clk);
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "bench timeout");
  end

  task automatic send_byte(input logic [7:0] b, input bit stop_ok);
    rx = 1'b0;
    repeat (BIT_CLK) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (BIT_CLK) @(negedge clk);
    end
    if (stop_ok) begin
      rx = 1'b1;
      repeat (BIT_CLK) @(negedge clk);
    end else begin
      // low across the stop sample point, high again before a false start is confirmed
      rx = 1'b0;
      repeat (BIT_CLK * 3 / 4) @(negedge clk);
      rx = 1'b1;
      repeat (BIT_CLK / 4) @(negedge clk);
    end
    repeat (BIT_CLK) @(negedge clk);
  endtask

  task automatic xmit(input logic [7:0] b, input bit ok);
    if (!ok) m_hdr = 0;
    else begin
      exp_q.push_back(b);
      if (!m_hdr) m_hdr = (b == 8'hA5);
      else begin
        m_pend = b;
        m_pv   = 1;
        m_hdr  = 0;
      end
    end
    send_byte(b, ok);
  endtask

  task automatic check_bytes(input string tag);
    chk({tag, "_nbytes"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++)
      if (i < got_q.size()) chk({tag, "_byte"}, got_q[i], exp_q[i]);
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic expect_duty(input string tag);
    int u0;
    u0 = n_upd;
    if (m_pv) begin
      for (int i = 0; i < 2 * PERIOD && n_upd == u0; i++) @(negedge clk);
      chk({tag, "_upd"}, n_upd - u0, 1);
      m_duty = m_pend;
      m_pv   = 0;
    end else begin
      repeat (PERIOD + 16) @(negedge clk);
      chk({tag, "_noupd"}, n_upd - u0, 0);
    end
    chk({tag, "_duty"}, duty, m_duty);
  endtask

  task automatic measure_pwm(input string tag);
    int hi;
    hi = 0;
    repeat (PERIOD) begin
      @(negedge clk);
      if (pwm_out) hi++;
    end
    chk(tag, hi, m_duty * PWM_DIV);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_rx_data"}, rx_data, 0);
    chk({tag, "_rx_done"}, rx_done, 0);
    chk({tag, "_frame_err"}, frame_err, 0);
    chk({tag, "_duty"}, duty, 0);
    chk({tag, "_duty_upd"}, duty_upd, 0);
    chk({tag, "_pwm_out"}, pwm_out, 0);
  endtask

  function automatic logic [7:0] rand_nonhdr();
    logic [7:0] v;
    v = 8'($urandom_range(0, 255));
    if (v == 8'hA5) v = 8'h5A;
    return v;
  endfunction

  initial begin
    int d0, f0, u0;
    logic [7:0] d;

    reset_n = 1'b0;
    rx = 1'b1;
    repeat (5) @(negedge clk);
    check_zero("reset");
    reset_n = 1'b1;
    repeat (10) @(negedge clk);

    // data bytes without a header leave the PWM off
    xmit(8'h80, 1);
    xmit(8'h3C, 1);
    check_bytes("nohdr");
    expect_duty("nohdr");
    measure_pwm("nohdr_pwm");

    // short low pulse on the line is rejected as a glitch
    d0 = n_done;
    f0 = n_ferr;
    rx = 1'b0;
    repeat (3 * BR_LIMIT) @(negedge clk);
    rx = 1'b1;
    repeat (11 * BIT_CLK) @(negedge clk);
    chk("glitch_done", n_done - d0, 0);
    chk("glitch_ferr", n_ferr - f0, 0);

    // basic frame, half duty
    xmit(8'hA5, 1);
    xmit(8'h80, 1);
    check_bytes("frame");
    expect_duty("frame");
    measure_pwm("frame_pwm");

    // framing error after a header discards it; following byte is not a duty
    f0 = n_ferr;
    xmit(8'hA5, 1);
    xmit(8'($urandom_range(0, 255)), 0);
    xmit(8'h40, 1);
    check_bytes("ferr");
    chk("ferr_cnt", n_ferr - f0, 1);
    chk("ferr_hold", rx_data, 8'h40);
    expect_duty("ferr");

    // two frames inside one period: only the last applies, one update
    for (int i = 0; i < PERIOD + 1 && (cyc % PERIOD) != 20; i++) @(negedge clk);
    u0 = n_upd;
    d = 8'($urandom_range(1, 254));
    xmit(8'hA5, 1);
    xmit(8'hFF, 1);
    xmit(8'hA5, 1);
    xmit(d, 1);
    check_bytes("dbl");
    expect_duty("dbl");
    repeat (PERIOD) @(negedge clk);
    chk("dbl_single", n_upd - u0, 1);
    measure_pwm("dbl_pwm");

    // random frames, each preceded by a random non-header byte
    for (int k = 0; k < 2; k++) begin
      xmit(rand_nonhdr(), 1);
      xmit(8'hA5, 1);
      xmit(8'($urandom_range(0, 255)), 1);
      check_bytes("rnd");
      expect_duty("rnd");
      measure_pwm("rnd_pwm");
    end

    // reset in the middle of the data bits
    d = rand_nonhdr();
    rx = 1'b0;
    repeat (BIT_CLK) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      rx = d[i];
      repeat (BIT_CLK) @(negedge clk);
    end
    reset_n = 1'b0;
    rx = 1'b1;
    repeat (4) @(negedge clk);
    check_zero("midrst");
    m_hdr = 0;
    m_pv = 0;
    m_duty = 8'h00;
    got_q.delete();
    exp_q.delete();
    d0 = n_done;
    f0 = n_ferr;
    reset_n = 1'b1;
    repeat (11 * BIT_CLK) @(negedge clk);
    chk("midrst_done", n_done - d0, 0);
    chk("midrst_ferr", n_ferr - f0, 0);
    xmit(8'hA5, 1);
    xmit(8'h00, 1);
    check_bytes("post");
    expect_duty("post");
    measure_pwm("post_pwm");

    chk("pulse_width", n_wide, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
